fft_inpl_cmult_sched: RTL
=========================

// Module: fft_inpl_cmult_sched
// PURPOSE
//  Schedules one shared complex multiplier (four fft_inpl_mac18x18mx instances, external) between two requesters:
//  req0 = butterfly twiddle multiply, req1 = window/scaling multiply.
//  Performs per-cycle arbitration, muxes the operands and drives the common MAC enables (en_a/en_b/en_p) and sync clears.
//  Carries a valid/source/tag sideband alongside the MAC pipeline and presents results with valid/ready backpressure.
// PARAMETERS
//  DW        18  operand/coef width, 2..18 (MAC sign-extends to 18)
//  RW        36  result width per component, taken from the datapath
//  TAGW      4   requester tag width, returned unchanged with the result
//  PIPE_LAT  3   MAC pipeline depth in advancing cycles (A/B reg, P reg, 2nd MAC P reg); range 1..6
//  RR        1   1 = round-robin; 0 = fixed priority, req0 wins
// PORTS
//  clk        in   1      single clock; all flops are rising-edge
//  rst        in   1      synchronous, active-high reset
//  reqN_valid in   1      N=0,1: operand valid
//  reqN_ready out  1      N=0,1: operand accepted this cycle
//  reqN_dre/dim  in  DW   N=0,1: data real/imag
//  reqN_cre/cim  in  DW   N=0,1: coefficient real/imag
//  reqN_tag   in   TAGW   N=0,1: opaque tag
//  mac_dre/dim   out DW   muxed data to the MAC A inputs
//  mac_cre/cim   out DW   muxed coef to the MAC B inputs
//  mac_en     out  1      drives en_a, en_b, en_p of all four MACs
//  mac_rstn   out  1      drives rstn (sync clear) of all MACs; = ~rst
//  mac_pre/pim   in  RW   MAC pipeline result real/imag
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts result
//  out_re/im  out  RW     = mac_pre/pim (passthrough, held by the MAC when stalled)
//  out_src    out  1      source requester of the result
//  out_tag    out  TAGW   tag of the result
//  busy       out  1      any valid in the pipeline
// BEHAVIOUR
//  Reset: while rst=1, all sideband valids clear; out_valid=0, busy=0, reqN_ready=0, mac_en=1 (MAC regs clear via mac_rstn=0).
//   RR pointer resets to favour req0. Reset mid-operation discards in-flight results with no partial output.
//  advance = ~out_valid | out_ready. mac_en = advance. When advance=0, the whole pipe freezes; bubbles are not squeezed.
//  Arbitration (combinational, on the current cycle):
//   - grant to the single valid requester.
//   - both valid: RR=1 grants the requester not granted last; RR=0 grants req0.
//   - reqN_ready = grant_N & advance & ~rst. Handshake is valid&ready; at most one accept per cycle.
//  Operand mux: mac_* = granted requester's fields. With no grant, mac_* = 0.
//   The zero entry flows through as a bubble with sideband valid=0.
//  Sideband: shift register of PIPE_LAT stages of {valid, src, tag}. It shifts only when advance=1.
//   Stage 0 loads {accept, grant_src, tag}. The last stage drives out_valid/out_src/out_tag.
//  Latency: an operand accepted at edge t yields out_valid exactly PIPE_LAT advancing edges later (PIPE_LAT cycles with no stall).
//  Throughput: 1 result/cycle when out_ready=1 and requests are continuous.
//  RR pointer updates only on an accept (it toggles to the non-served side).
//   With req0 only, the pointer does not starve req1 on later contention.
//  Stall with out_valid=1, out_ready=0: out_* and the MAC P regs hold, reqN_ready=0, and the requesters must hold their data.
//  Simultaneous out_ready and new accept in the same cycle is legal: output retires and pipe advances.
//  busy = OR of all sideband valid bits.
//  Arithmetic is performed by the MAC datapath. This block adds no width growth and no rounding.
// STRUCTURE
//  Shared include fft_inpl_sched_defs.vh: SRC_BFLY=1'b0, SRC_WIN=1'b1, and the PIPE_LAT range check constants.
//  Sub-module fft_inpl_rr_arb2: 2-way arbiter with RR/fixed mode and a pointer updated on accept.
//  Top level: arbiter, operand mux, sideband shift register, and the advance logic.
//  Elaboration $display error if PIPE_LAT is outside 1..6 or DW > 18.
// TESTING
//  T1 reset: rst=1 for 3 cycles with both valids high -> readies=0, out_valid=0, busy=0, mac_rstn=0.
//  T2 single: req0 (dre=5, cre=3, tag=7) for 1 cycle, out_ready=1 -> out_valid at +3 cycles, src=0, tag=7, one pulse only.
//  T3 contention: RR=1, both valid for 8 cycles -> grants alternate 0,1,0,1...; 4 results per source with tags in order.
//   With RR=0 -> req0 receives all 8 grants.
//  T4 backpressure: stream 10 ops, drop out_ready for 5 cycles at result 4 -> out_* stable, readies=0, mac_en=0.
//   No loss or duplication; all 10 results complete.
//  T5 reset mid-flight: 2 ops in the pipe, rst=1 for 1 cycle -> no out_valid afterwards, busy=0, next op latency = PIPE_LAT.
//  T6 sparse: req1 valid on alternate cycles, out_ready random 50% -> scoreboard matches tag/src order and complex products.

Source files
------------

// File: rtl/fft_inpl_cmult_sched_pkg.sv
// Shared constants and types for the complex-multiplier scheduler.
package fft_inpl_cmult_sched_pkg;

    // Source identifiers carried in the sideband and returned on out_src.
    localparam logic SRC_BFLY = 1'b0;
    localparam logic SRC_WIN  = 1'b1;

    // Legal parameter ranges for the shared MAC pipeline.
    localparam int PIPE_LAT_MIN = 1;
    localparam int PIPE_LAT_MAX = 6;
    localparam int DW_MIN       = 2;
    localparam int DW_MAX       = 18;

    // Round-robin pointer: which requester wins the next contention.
    typedef enum logic {
        FAVOR_REQ0 = 1'b0,
        FAVOR_REQ1 = 1'b1
    } rr_ptr_e;

endpackage

// File: rtl/fft_inpl_cmult_sched_rr_arb2.sv
// Two-way arbiter, round-robin or fixed priority (req0 wins).
// The pointer moves only on an accepted grant, to the side not served.
module fft_inpl_cmult_sched_rr_arb2
    import fft_inpl_cmult_sched_pkg::*;
#(
    parameter int RR = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic valid0,
    input  logic valid1,
    input  logic accept,
    output logic grant_valid,
    output logic grant_src
);

    rr_ptr_e ptr;

    // Combinational grant for the current cycle.
    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latch is inferred.
        grant_valid = valid0 | valid1;
        grant_src   = SRC_BFLY;
        if (valid1 && (!valid0 || (RR != 0 && ptr == FAVOR_REQ1)))
            grant_src = SRC_WIN;
    end

    // Pointer register: favour the side that was not just served.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops sample together.
        if (rst)
            ptr <= FAVOR_REQ0;
        else if (accept)
            ptr <= (grant_src == SRC_BFLY) ? FAVOR_REQ1 : FAVOR_REQ0;
    end

endmodule

// File: rtl/fft_inpl_cmult_sched.sv
// Shares one complex MAC pipeline between the butterfly and window requesters.
// Arbitrates, muxes operands, drives MAC enables/clear and tracks a
// valid/src/tag sideband that lines up with the MAC result.
module fft_inpl_cmult_sched
    import fft_inpl_cmult_sched_pkg::*;
#(
    parameter int DW       = 18,
    parameter int RW       = 36,
    parameter int TAGW     = 4,
    parameter int PIPE_LAT = 3,
    parameter int RR       = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [DW-1:0]   req0_dre,
    input  logic [DW-1:0]   req0_dim,
    input  logic [DW-1:0]   req0_cre,
    input  logic [DW-1:0]   req0_cim,
    input  logic [TAGW-1:0] req0_tag,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [DW-1:0]   req1_dre,
    input  logic [DW-1:0]   req1_dim,
    input  logic [DW-1:0]   req1_cre,
    input  logic [DW-1:0]   req1_cim,
    input  logic [TAGW-1:0] req1_tag,
    output logic [DW-1:0]   mac_dre,
    output logic [DW-1:0]   mac_dim,
    output logic [DW-1:0]   mac_cre,
    output logic [DW-1:0]   mac_cim,
    output logic            mac_en,
    output logic            mac_rstn,
    input  logic [RW-1:0]   mac_pre,
    input  logic [RW-1:0]   mac_pim,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [RW-1:0]   out_re,
    output logic [RW-1:0]   out_im,
    output logic            out_src,
    output logic [TAGW-1:0] out_tag,
    output logic            busy
);

    if (PIPE_LAT < PIPE_LAT_MIN || PIPE_LAT > PIPE_LAT_MAX || DW < DW_MIN || DW > DW_MAX)
    begin : g_param_check
        $error("fft_inpl_cmult_sched: PIPE_LAT must be 1..6 and DW 2..18");
    end

    logic                grant_valid;
    logic                grant_src;
    logic                advance;
    logic                accept;
    logic [PIPE_LAT-1:0] sb_valid;
    logic [PIPE_LAT-1:0] sb_src;
    logic [TAGW-1:0]     sb_tag [PIPE_LAT];

    // The whole pipe (MAC and sideband) moves together; a held result freezes it.
    assign out_valid  = sb_valid[PIPE_LAT-1] & ~rst;
    assign advance    = ~out_valid | out_ready;
    assign accept     = grant_valid & advance & ~rst;
    assign req0_ready = accept & (grant_src == SRC_BFLY);
    assign req1_ready = accept & (grant_src == SRC_WIN);
    assign mac_en     = advance;
    assign mac_rstn   = ~rst;
    assign out_re     = mac_pre;
    assign out_im     = mac_pim;
    assign out_src    = sb_src[PIPE_LAT-1];
    assign out_tag    = sb_tag[PIPE_LAT-1];
    assign busy       = (|sb_valid) & ~rst;

    fft_inpl_cmult_sched_rr_arb2 #(.RR(RR)) u_arb (
        .clk         (clk),
        .rst         (rst),
        .valid0      (req0_valid),
        .valid1      (req1_valid),
        .accept      (accept),
        .grant_valid (grant_valid),
        .grant_src   (grant_src)
    );

    // Operand mux: granted requester's fields, zeros for a bubble.
    always_comb begin
        mac_dre = '0;
        mac_dim = '0;
        mac_cre = '0;
        mac_cim = '0;
        if (grant_valid) begin
            if (grant_src == SRC_WIN) begin
                mac_dre = req1_dre;
                mac_dim = req1_dim;
                mac_cre = req1_cre;
                mac_cim = req1_cim;
            end else begin
                mac_dre = req0_dre;
                mac_dim = req0_dim;
                mac_cre = req0_cre;
                mac_cim = req0_cim;
            end
        end
    end

    // Sideband valid shift register; cleared by reset so in-flight results vanish.
    always_ff @(posedge clk) begin
        if (rst) begin
            sb_valid <= '0;
        end else if (advance) begin
            for (int i = PIPE_LAT - 1; i > 0; i--)
                sb_valid[i] <= sb_valid[i-1];
            sb_valid[0] <= accept;
        end
    end

    // Sideband payload shift register, qualified by sb_valid.
    always_ff @(posedge clk) begin
        // NOTE: payload is not reset; it is only observed when its valid bit is set.
        if (advance) begin
            for (int i = PIPE_LAT - 1; i > 0; i--) begin
                sb_src[i] <= sb_src[i-1];
                sb_tag[i] <= sb_tag[i-1];
            end
            sb_src[0] <= grant_src;
            sb_tag[0] <= (grant_src == SRC_WIN) ? req1_tag : req0_tag;
        end
    end

endmodule
